// File: rtl/rom_port_arbiter.sv
// Shares one single-port synchronous ROM RAM between the HPS download writer
// and the main/sound Z80 fetch paths; writes win, reads are round-robin.
module rom_port_arbiter #(
  parameter int unsigned     AW       = 16,
  parameter int unsigned     DW       = 8,
  parameter int unsigned     LAT      = 2,
  parameter logic [AW-1:0]   SND_BASE = 16'hC000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_data,
  input  logic          snd_req,
  input  logic [13:0]   snd_addr,
  output logic          snd_ack,
  output logic [DW-1:0] snd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_q,
  output logic          dl_overflow
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_DONE} state_t;

  state_t        state, state_d;
  logic          pend, pend_d;
  logic [AW-1:0] hold_addr, hold_addr_d;
  logic [DW-1:0] hold_data, hold_data_d;
  logic          rr_snd, rr_snd_d;
  logic          grant_snd, grant_snd_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          cpu_ack_d, snd_ack_d, mem_we_d, overflow_d;
  logic [DW-1:0] cpu_data_d, snd_data_d, mem_din_d;
  logic [AW-1:0] mem_addr_d;
  logic          pend_clr, pick_snd;

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pend        <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      rr_snd      <= 1'b0;
      grant_snd   <= 1'b0;
      cnt         <= '0;
      cpu_ack     <= 1'b0;
      cpu_data    <= '0;
      snd_ack     <= 1'b0;
      snd_data    <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_din     <= '0;
      dl_overflow <= 1'b0;
    end else begin
      state       <= state_d;
      pend        <= pend_d;
      hold_addr   <= hold_addr_d;
      hold_data   <= hold_data_d;
      rr_snd      <= rr_snd_d;
      grant_snd   <= grant_snd_d;
      cnt         <= cnt_d;
      cpu_ack     <= cpu_ack_d;
      cpu_data    <= cpu_data_d;
      snd_ack     <= snd_ack_d;
      snd_data    <= snd_data_d;
      mem_addr    <= mem_addr_d;
      mem_we      <= mem_we_d;
      mem_din     <= mem_din_d;
      dl_overflow <= overflow_d;
    end
  end

  // Next-state, download capture and arbitration
  always_comb begin
    state_d     = state;
    pend_d      = pend;
    hold_addr_d = hold_addr;
    hold_data_d = hold_data;
    rr_snd_d    = rr_snd;
    grant_snd_d = grant_snd;
    cnt_d       = cnt;
    cpu_ack_d   = 1'b0;
    cpu_data_d  = cpu_data;
    snd_ack_d   = 1'b0;
    snd_data_d  = snd_data;
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_din_d   = mem_din;
    overflow_d  = dl_overflow;
    pend_clr    = (state == S_WRITE);
    pick_snd    = snd_req && (!cpu_req || rr_snd);

    // A write landing on the clearing edge refills the slot instead of overflowing
    if (dl_wr) begin
      if (pend && !pend_clr) begin
        overflow_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        hold_addr_d = dl_addr;
        hold_data_d = dl_data;
      end
    end else if (pend_clr) begin
      pend_d = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (pend) begin
          mem_addr_d = hold_addr;
          mem_din_d  = hold_data;
          mem_we_d   = 1'b1;
          state_d    = S_WRITE;
        end else if (!dl_active && (cpu_req || snd_req)) begin
          if (cpu_req && snd_req) rr_snd_d = !pick_snd;
          grant_snd_d = pick_snd;
          mem_addr_d  = pick_snd ? (SND_BASE | AW'(snd_addr)) : cpu_addr;
          cnt_d       = CW'(LAT);
          state_d     = S_WAIT;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (grant_snd) begin
            snd_data_d = mem_q;
            snd_ack_d  = 1'b1;
          end else begin
            cpu_data_d = mem_q;
            cpu_ack_d  = 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a combinational ROM model.
module tb_rom_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_req, cpu_ack, snd_req, snd_ack;
  logic [15:0] cpu_addr, mem_addr;
  logic [13:0] snd_addr;
  logic [7:0]  cpu_data, snd_data, mem_din, mem_q;
  logic        mem_we, dl_overflow;

  int errors = 0;
  int checks = 0;

  // ROM contents: q = lo ^ hi ^ 3C
  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign mem_q = rom_f(mem_addr);

  always #5 clk_sys = ~clk_sys;

  rom_port_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack), .cpu_data(cpu_data), .snd_req(snd_req), .snd_addr(snd_addr),
    .snd_ack(snd_ack), .snd_data(snd_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_q(mem_q), .dl_overflow(dl_overflow)
  );

  // Exclusivity of acks and writes on every cycle out of reset
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1) begin
      checks++;
      if ((cpu_ack && snd_ack) || ((cpu_ack || snd_ack) && mem_we)) begin
        errors++;
        $display("FAIL exclusive: cpu_ack=%b snd_ack=%b mem_we=%b", cpu_ack, snd_ack, mem_we);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_addr = '0; snd_req = 1'b0; snd_addr = '0;
    tick(); tick();
    checks++;
    if ({cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_din, dl_overflow} !== 46'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_din, dl_overflow});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_addr = 16'h1234; cpu_req = 1'b1;
    tick();
    checks++;
    if (mem_addr !== 16'h1234 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_grant: mem_addr=%h ack=%b required 1234/0", mem_addr, cpu_ack);
    end
    cpu_addr = 16'hFFFF;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || mem_addr !== 16'h1234) begin
      errors++; $display("FAIL cpu_wait: ack=%b mem_addr=%h required 0/1234", cpu_ack, mem_addr);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'h1A || snd_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_ack: ack=%b data=%h snd_ack=%b required 1/1a/0", cpu_ack, cpu_data, snd_ack);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_data !== 8'h1A) begin
      errors++; $display("FAIL cpu_hold: ack=%b data=%h required 0/1a", cpu_ack, cpu_data);
    end
    tick();
  endtask

  task automatic test_snd_read();
    snd_addr = 14'h0010; snd_req = 1'b1;
    tick();
    checks++;
    if (mem_addr !== 16'hC010) begin
      errors++; $display("FAIL snd_addr: mem_addr=%h required c010", mem_addr);
    end
    tick();
    checks++;
    if (snd_ack !== 1'b0) begin
      errors++; $display("FAIL snd_early: ack=%b required 0", snd_ack);
    end
    tick();
    checks++;
    if (snd_ack !== 1'b1 || snd_data !== 8'hEC || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL snd_ack: ack=%b data=%h cpu_ack=%b required 1/ec/0", snd_ack, snd_data, cpu_ack);
    end
    snd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int n_ack;
    int last;
    logic exp_snd;
    n_ack = 0; last = 0; exp_snd = 1'b0;
    cpu_addr = 16'h0100; snd_addr = 14'h0020; cpu_req = 1'b1; snd_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_ack || snd_ack) begin
        checks++;
        if (snd_ack !== exp_snd || (n_ack > 0 && i - last != 4) ||
            (!exp_snd && cpu_data !== 8'h3D) || (exp_snd && snd_data !== 8'hDC)) begin
          errors++;
          $display("FAIL rr_grant: cycle=%0d snd_ack=%b cpu=%h snd=%h required snd_ack=%b gap 4",
                   i, snd_ack, cpu_data, snd_data, exp_snd);
        end
        exp_snd = ~exp_snd; last = i; n_ack++;
      end
    end
    checks++;
    if (n_ack != 4) begin
      errors++; $display("FAIL rr_count: acks=%0d required 4", n_ack);
    end
    cpu_req = 1'b0; snd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_download();
    int acks;
    acks = 0;
    dl_active = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0200;
    dl_wr = 1'b1; dl_addr = 16'h0005; dl_data = 8'hA5;
    tick();
    dl_wr = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL dl_capture: mem_we=%b required 0", mem_we);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0005 || mem_din !== 8'hA5) begin
      errors++; $display("FAIL dl_write: we=%b addr=%h din=%h required 1/0005/a5", mem_we, mem_addr, mem_din);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL dl_write_len: mem_we=%b required 0", mem_we);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL dl_block: acks=%0d required 0", acks);
    end
    dl_active = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'h3E) begin
      errors++; $display("FAIL dl_release: ack=%b data=%h required 1/3e", cpu_ack, cpu_data);
    end
    cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wr_clear_edge();
    dl_wr = 1'b1; dl_addr = 16'h0010; dl_data = 8'h11;
    tick();
    dl_wr = 1'b0;
    tick();
    dl_wr = 1'b1; dl_addr = 16'h0011; dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || dl_overflow !== 1'b0) begin
      errors++; $display("FAIL clr_edge: we=%b ovf=%b required 0/0", mem_we, dl_overflow);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0011 || mem_din !== 8'h22) begin
      errors++; $display("FAIL clr_edge_wr: we=%b addr=%h din=%h required 1/0011/22", mem_we, mem_addr, mem_din);
    end
    tick(); tick();
  endtask

  task automatic test_overflow();
    int writes;
    writes = 0;
    dl_wr = 1'b1; dl_addr = 16'h0020; dl_data = 8'h33;
    tick();
    dl_addr = 16'h0021; dl_data = 8'h44;
    tick();
    dl_wr = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_din !== 8'h33 || dl_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_first: we=%b addr=%h din=%h ovf=%b required 1/0020/33/1",
                         mem_we, mem_addr, mem_din, dl_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_we) writes++;
    end
    checks++;
    if (writes != 0 || dl_overflow !== 1'b1 || mem_addr !== 16'h0020) begin
      errors++; $display("FAIL ovf_drop: writes=%0d ovf=%b addr=%h required 0/1/0020", writes, dl_overflow, mem_addr);
    end
  endtask

  task automatic test_dl_active_wait();
    cpu_req = 1'b1; cpu_addr = 16'h0300;
    tick();
    dl_active = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'h3F) begin
      errors++; $display("FAIL dl_in_wait: ack=%b data=%h required 1/3f", cpu_ack, cpu_data);
    end
    cpu_req = 1'b0; dl_active = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0400;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_din, dl_overflow} !== 46'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h required 0",
               {cpu_ack, cpu_data, snd_ack, snd_data, mem_addr, mem_we, mem_din, dl_overflow});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL mid_reset_ack: acks=%0d required 0", acks);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (mem_addr !== 16'h0400) begin
      errors++; $display("FAIL post_reset_grant: mem_addr=%h required 0400", mem_addr);
    end
    tick(); tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'h38) begin
      errors++; $display("FAIL post_reset_ack: ack=%b data=%h required 1/38", cpu_ack, cpu_data);
    end
    cpu_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_snd_read();
    test_round_robin();
    test_download();
    test_wr_clear_edge();
    test_overflow();
    test_dl_active_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
